// File: rtl/accel_pkg.sv
// accel_pkg: shared register map, DEVID, FSM states and sample width for the accelerometer SPI responder.
package accel_pkg;
    localparam int         SAMPLE_W     = 48;
    localparam logic [7:0] DEVID        = 8'hE5;
    localparam logic [5:0] A_DEVID      = 6'h00;
    localparam logic [5:0] A_INT_ENABLE = 6'h2E;
    localparam logic [5:0] A_INT_SOURCE = 6'h30;
    localparam logic [5:0] A_DATAX0     = 6'h32;
    localparam logic [5:0] A_DATAZ1     = 6'h37;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_READ, S_WRITE} state_t;

    function automatic logic is_data(input logic [5:0] a);
        return a >= A_DATAX0 && a <= A_DATAZ1;
    endfunction

    function automatic logic is_ro(input logic [5:0] a);
        return a == A_DEVID || a == A_INT_SOURCE || is_data(a);
    endfunction
endpackage

// File: rtl/accel_spi_sync.sv
// accel_spi_sync: 2-flop synchronizer with rising/falling edge detect on the synchronized value.
module accel_spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [2:0] r_q;

    always_ff @(posedge i_clk)
        r_q <= i_rst ? {3{RST_VAL}} : {r_q[1:0], i_d};

    assign o_q    = r_q[1];
    assign o_rise = r_q[1] & ~r_q[2];
    assign o_fall = ~r_q[1] & r_q[2];
endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: 3-wire mode-3 SPI register responder with coherent X/Y/Z sample capture.
// Define ACCEL_SPI_RESPONDER_INT_EN to drive spi_int from INT_SOURCE[7] & INT_ENABLE[7].
module accel_spi_responder
    import accel_pkg::*;
(
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                spi_sclk,
    input  logic                spi_cs_n,
    input  logic                spi_sdat_in,
    output logic                spi_sdat_out,
    output logic                spi_sdat_oe,
    output logic                spi_int,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_xyz
);
    logic       w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic       w_cs_q, w_cs_rise, w_cs_fall;
    logic       w_sdi, w_sdi_rise, w_sdi_fall;
    logic       w_unused;
    state_t     r_state, w_next;
    logic [2:0] r_cnt;
    logic [6:0] r_shift;
    logic [5:0] r_addr;
    logic       r_mb;
    logic [7:0] r_tx;
    logic       r_oe;
    logic [7:0] r_regs [64];
    logic [7:0] w_byte;
    logic       w_byte_done, w_wr_en, w_rd_clr, w_accept;

    // CS sync resets low so a frame already in progress at reset release never shows a falling edge.
    accel_spi_sync #(.RST_VAL(1'b1)) u_sync_sclk (.i_clk(clk_clk), .i_rst(reset_reset), .i_d(spi_sclk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    accel_spi_sync #(.RST_VAL(1'b0)) u_sync_cs (.i_clk(clk_clk), .i_rst(reset_reset), .i_d(spi_cs_n),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    accel_spi_sync #(.RST_VAL(1'b0)) u_sync_sdi (.i_clk(clk_clk), .i_rst(reset_reset), .i_d(spi_sdat_in),
        .o_q(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall));

    assign w_unused    = ^{w_sclk_q, w_cs_rise, w_sdi_rise, w_sdi_fall};
    assign w_byte      = {r_shift, w_sdi};
    assign w_byte_done = !w_cs_q && w_sclk_rise && r_cnt == 3'd7;
    assign w_wr_en     = r_state == S_WRITE && w_byte_done && !is_ro(r_addr);
    assign w_rd_clr    = r_state == S_READ && w_byte_done && is_data(r_addr);
    assign sample_ready = w_cs_q;
    assign w_accept    = sample_valid && sample_ready;
    assign spi_sdat_oe  = r_oe;
    assign spi_sdat_out = r_oe ? r_tx[7] : 1'b1;

    always_ff @(posedge clk_clk)
        r_state <= reset_reset ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        if (w_cs_q)
            w_next = S_IDLE;
        else if (r_state == S_IDLE && w_cs_fall)
            w_next = S_CMD;
        else if (r_state == S_CMD && w_byte_done)
            w_next = w_byte[7] ? S_READ : S_WRITE;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cnt   <= 3'd0;
            r_shift <= 7'd0;
            r_addr  <= 6'd0;
            r_mb    <= 1'b0;
            r_tx    <= 8'hFF;
            r_oe    <= 1'b0;
        end else if (r_state == S_IDLE || w_cs_q) begin
            r_cnt <= 3'd0;
            r_oe  <= 1'b0;
        end else begin
            if (w_sclk_rise) begin
                r_cnt   <= r_cnt + 3'd1;
                r_shift <= w_byte[6:0];
            end
            if (r_state == S_CMD && w_byte_done) begin
                r_addr <= w_byte[5:0];
                r_mb   <= w_byte[6];
            end
            if (r_state != S_CMD && w_byte_done && r_mb)
                r_addr <= r_addr + 6'd1;
            // Mode 3: the initiator samples on rising SCLK, so data moves on the falling edge.
            if (r_state == S_READ && w_sclk_fall) begin
                r_oe <= 1'b1;
                r_tx <= r_cnt == 3'd0 ? r_regs[r_addr] : {r_tx[6:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < 64; i++)
                r_regs[6'(i)] <= 8'h00;
            r_regs[A_DEVID] <= DEVID;
        end else begin
            if (w_wr_en)
                r_regs[r_addr] <= w_byte;
            if (w_rd_clr)
                r_regs[A_INT_SOURCE][7] <= 1'b0;
            // Later assignment wins, so a sample landing with a data read keeps DATA_READY set.
            if (w_accept) begin
                for (int i = 0; i < 6; i++)
                    r_regs[A_DATAX0 + 6'(i)] <= sample_xyz[8*i +: 8];
                r_regs[A_INT_SOURCE][7] <= 1'b1;
            end
        end
    end

`ifdef ACCEL_SPI_RESPONDER_INT_EN
    logic r_int;
    always_ff @(posedge clk_clk)
        r_int <= reset_reset ? 1'b0 : r_regs[A_INT_SOURCE][7] & r_regs[A_INT_ENABLE][7];
    assign spi_int = r_int;
`else
    assign spi_int = 1'b0;
`endif
endmodule

// File: tb/tb_accel_spi_responder.sv
// tb_accel_spi_responder: directed mode-3 SPI frames against accel_spi_responder with hand-computed expectations.
module tb_accel_spi_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo, oe, irq, ready;
    logic        valid = 1'b0;
    logic [47:0] xyz = 48'h0;
    logic [7:0]  rx;
    logic        oe_all;
    int          errors = 0;
    int          checks = 0;

`ifdef ACCEL_SPI_RESPONDER_INT_EN
    localparam logic EXP_INT = 1'b1;
`else
    localparam logic EXP_INT = 1'b0;
`endif

    accel_spi_responder dut (
        .clk_clk(clk), .reset_reset(rst), .spi_sclk(sclk), .spi_cs_n(cs_n),
        .spi_sdat_in(sdi), .spi_sdat_out(sdo), .spi_sdat_oe(oe), .spi_int(irq),
        .sample_valid(valid), .sample_ready(ready), .sample_xyz(xyz)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic shift(input logic [7:0] d, input int n);
        rx = 8'h00;
        oe_all = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            sdi  = d[i];
            repeat (4) @(negedge clk);
            rx[i]  = sdo;
            oe_all = oe_all & oe;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic write_reg(input logic [5:0] a, input logic [7:0] d);
        cs_low();
        shift({2'b00, a}, 8);
        shift(d, 8);
        cs_high();
    endtask

    task automatic read_reg(input logic [5:0] a, output logic [7:0] q);
        cs_low();
        shift({2'b10, a}, 8);
        shift(8'hFF, 8);
        q = rx;
        cs_high();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b exp 0", oe); end
        checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL reset_sdo: got %b exp 1", sdo); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_int: got %b exp 0", irq); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b exp 1", ready); end
    endtask

    task automatic test_devid();
        cs_low();
        shift(8'h80, 8);
        shift(8'hFF, 8);
        checks++; if (rx !== 8'hE5) begin errors++; $display("FAIL devid: got %h exp e5", rx); end
        checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL devid_oe: got %b exp 1", oe_all); end
        cs_high();
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL devid_oe_drop: got %b exp 0", oe); end
    endtask

    task automatic test_int_data();
        logic [7:0] q;
        logic [7:0] got [6];
        logic [7:0] exp_b [6];
        exp_b = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
        write_reg(6'h2E, 8'h80);
        xyz = 48'h0003_0002_0001;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (irq !== EXP_INT) begin errors++; $display("FAIL int_set: got %b exp %b", irq, EXP_INT); end
        read_reg(6'h30, q);
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL int_source: got %h exp 80", q); end
        cs_low();
        shift(8'hF2, 8);
        checks++; if (irq !== EXP_INT) begin errors++; $display("FAIL int_before_data: got %b exp %b", irq, EXP_INT); end
        for (int b = 0; b < 6; b++) begin
            shift(8'hFF, 8);
            got[b] = rx;
            if (b == 0) begin
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_clear: got %b exp 0", irq); end
            end
        end
        cs_high();
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (got[b] !== exp_b[b]) begin errors++; $display("FAIL mb_read[%0d]: got %h exp %h", b, got[b], exp_b[b]); end
        end
        read_reg(6'h30, q);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL int_source_clr: got %h exp 00", q); end
    endtask

    task automatic test_mb_wrap();
        logic [7:0] q;
        logic [7:0] got [3];
        cs_low();
        shift(8'h7E, 8);
        shift(8'hAA, 8);
        shift(8'hBB, 8);
        cs_high();
        cs_low();
        shift(8'hFE, 8);
        for (int b = 0; b < 3; b++) begin
            shift(8'hFF, 8);
            got[b] = rx;
        end
        cs_high();
        checks++; if (got[0] !== 8'hAA) begin errors++; $display("FAIL mb_3e: got %h exp aa", got[0]); end
        checks++; if (got[1] !== 8'hBB) begin errors++; $display("FAIL mb_3f: got %h exp bb", got[1]); end
        checks++; if (got[2] !== 8'hE5) begin errors++; $display("FAIL mb_wrap_read: got %h exp e5", got[2]); end
        cs_low();
        shift(8'h7F, 8);
        shift(8'hCC, 8);
        shift(8'h11, 8);
        cs_high();
        read_reg(6'h3F, q);
        checks++; if (q !== 8'hCC) begin errors++; $display("FAIL wrap_3f: got %h exp cc", q); end
        read_reg(6'h00, q);
        checks++; if (q !== 8'hE5) begin errors++; $display("FAIL wrap_devid: got %h exp e5", q); end
    endtask

    task automatic test_stall();
        logic [7:0] q, b0, b1;
        int n;
        cs_low();
        xyz = 48'h0006_0005_0004;
        valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b exp 0", ready); end
        shift(8'hF2, 8);
        shift(8'hFF, 8);
        b0 = rx;
        shift(8'hFF, 8);
        b1 = rx;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL stall_ready_late: got %b exp 0", ready); end
        checks++; if (b0 !== 8'h01) begin errors++; $display("FAIL stall_x0: got %h exp 01", b0); end
        checks++; if (b1 !== 8'h00) begin errors++; $display("FAIL stall_x1: got %h exp 00", b1); end
        cs_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n < 1 || n > 3) begin errors++; $display("FAIL stall_release: got %0d cycles exp 1..3", n); end
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        read_reg(6'h32, q);
        checks++; if (q !== 8'h04) begin errors++; $display("FAIL stall_new_x0: got %h exp 04", q); end
        read_reg(6'h36, q);
        checks++; if (q !== 8'h06) begin errors++; $display("FAIL stall_new_z0: got %h exp 06", q); end
    endtask

    task automatic test_abort();
        logic [7:0] q;
        cs_low();
        shift(8'h1D, 8);
        shift(8'hF0, 4);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        read_reg(6'h1D, q);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL abort_write: got %h exp 00", q); end
        write_reg(6'h1D, 8'h5A);
        read_reg(6'h1D, q);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL after_abort: got %h exp 5a", q); end
        cs_low();
        shift(8'h80, 8);
        shift(8'hFF, 3);
        checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL abort_read_oe: got %b exp 1", oe_all); end
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL abort_oe_drop: got %b exp 0", oe); end
        checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL abort_sdo: got %b exp 1", sdo); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] q;
        cs_low();
        shift(8'h1D, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        shift(8'h5D, 8);
        shift(8'h42, 8);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b exp 0", oe); end
        cs_high();
        read_reg(6'h1D, q);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_mid_reg: got %h exp 00", q); end
        read_reg(6'h00, q);
        checks++; if (q !== 8'hE5) begin errors++; $display("FAIL rst_mid_devid: got %h exp e5", q); end
    endtask

    initial begin
        test_reset();
        test_devid();
        test_int_data();
        test_mb_wrap();
        test_stall();
        test_abort();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
